// File: rtl/spi_slave_mem.sv
`default_nettype none
// spi_slave_mem -- SPI slave (any CPOL/CPHA) in front of a word memory, plus a clk-domain backdoor port.
// Revision 1.0
module spi_slave_mem #(
  parameter int WORD_BITS  = 8,
  parameter int ADDR_BYTES = 1,
  parameter int DEPTH      = 256,
  parameter bit CPOL       = 1'b0,
  parameter bit CPHA       = 1'b0,
  localparam int ADDR_W    = $clog2(DEPTH)
) (
  input  logic                 clk,
  input  logic                 resetn,
  input  logic                 spi_csb,
  input  logic                 spi_sck,
  input  logic                 spi_mosi,
  output logic                 spi_miso,
  output logic                 spi_miso_oe,
  input  logic                 bd_we,
  input  logic [ADDR_W-1:0]    bd_addr,
  input  logic [WORD_BITS-1:0] bd_wdata,
  output logic [WORD_BITS-1:0] bd_rdata,
  output logic                 busy,
  output logic                 xfer_done,
  output logic                 cmd_err
);

  localparam int ADDR_BITS       = ADDR_BYTES * 8;
  localparam int RX_W            = (WORD_BITS > ADDR_BITS) ? WORD_BITS : ADDR_BITS;
  localparam logic [5:0] BYTE_LAST = 6'd7;
  localparam logic [5:0] ADDR_LAST = 6'(ADDR_BITS - 1);
  localparam logic [5:0] WORD_LAST = 6'(WORD_BITS - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_CMD, S_ADDR, S_RDATA, S_WDATA, S_STATUS, S_IGNORE
  } state_e;

  logic csb_m_q, csb_s_q, csb_p_q;
  logic sck_m_q, sck_s_q, sck_p_q;
  logic mosi_m_q, mosi_s_q;
  logic [1:0] settle_q;
  logic armed_q;

  state_e state_q, state_d;
  logic [5:0] cnt_q, cnt_d;
  logic [RX_W-2:0] rx_q, rx_d;
  logic [RX_W-1:0] rx_next;
  logic [WORD_BITS-1:0] tx_q, tx_d;
  logic miso_q, miso_d;
  logic [ADDR_W-1:0] ptr_q, ptr_d;
  logic is_rd_q, is_rd_d;
  logic wrapped_q, wrapped_d;
  logic last_err_q, last_err_d;
  logic cmd_err_q, cmd_err_d;
  logic done_q, done_d;
  logic mem_we;
  logic [WORD_BITS-1:0] mem_wdata, rd_word, stat_word;
  logic [WORD_BITS-1:0] bd_rdata_q;
  logic [WORD_BITS-1:0] mem_q [DEPTH];

  logic sck_rise, sck_fall, sck_lead, sck_trail, smp_edge, shf_edge, csb_fall, csb_rise;

  assign sck_rise  = sck_s_q & ~sck_p_q;
  assign sck_fall  = ~sck_s_q & sck_p_q;
  assign sck_lead  = CPOL ? sck_fall : sck_rise;
  assign sck_trail = CPOL ? sck_rise : sck_fall;
  assign smp_edge  = CPHA ? sck_trail : sck_lead;
  assign shf_edge  = CPHA ? sck_lead : sck_trail;
  // A fall only counts once CSB has been seen high after reset, so a reset inside a transfer waits for the next one.
  assign csb_fall  = armed_q & csb_p_q & ~csb_s_q;
  assign csb_rise  = ~csb_p_q & csb_s_q;
  assign rx_next   = {rx_q, mosi_s_q};

  always_ff @(posedge clk) begin
    if (!resetn) begin
      csb_m_q    <= 1'b1;
      csb_s_q    <= 1'b1;
      csb_p_q    <= 1'b1;
      sck_m_q    <= CPOL;
      sck_s_q    <= CPOL;
      sck_p_q    <= CPOL;
      mosi_m_q   <= 1'b0;
      mosi_s_q   <= 1'b0;
      settle_q   <= 2'b11;
      armed_q    <= 1'b0;
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      rx_q       <= '0;
      tx_q       <= '0;
      miso_q     <= 1'b0;
      ptr_q      <= '0;
      is_rd_q    <= 1'b0;
      wrapped_q  <= 1'b0;
      last_err_q <= 1'b0;
      cmd_err_q  <= 1'b0;
      done_q     <= 1'b0;
      bd_rdata_q <= '0;
    end else begin
      csb_m_q    <= spi_csb;
      csb_s_q    <= csb_m_q;
      csb_p_q    <= csb_s_q;
      sck_m_q    <= spi_sck;
      sck_s_q    <= sck_m_q;
      sck_p_q    <= sck_s_q;
      mosi_m_q   <= spi_mosi;
      mosi_s_q   <= mosi_m_q;
      settle_q   <= {settle_q[0], 1'b0};
      armed_q    <= armed_q | (csb_s_q & ~settle_q[1]);
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      rx_q       <= rx_d;
      tx_q       <= tx_d;
      miso_q     <= miso_d;
      ptr_q      <= ptr_d;
      is_rd_q    <= is_rd_d;
      wrapped_q  <= wrapped_d;
      last_err_q <= last_err_d;
      cmd_err_q  <= cmd_err_d;
      done_q     <= done_d;
      bd_rdata_q <= mem_q[bd_addr];
    end
  end

  // SPI write is applied last so it wins an address collision with the backdoor.
  always_ff @(posedge clk) begin
    if (bd_we) mem_q[bd_addr] <= bd_wdata;
    if (mem_we && resetn) mem_q[ptr_q] <= mem_wdata;
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    rx_d       = rx_q;
    tx_d       = tx_q;
    miso_d     = miso_q;
    ptr_d      = ptr_q;
    is_rd_d    = is_rd_q;
    wrapped_d  = wrapped_q;
    last_err_d = last_err_q;
    cmd_err_d  = 1'b0;
    done_d     = 1'b0;
    mem_we     = 1'b0;
    mem_wdata  = rx_next[WORD_BITS-1:0];
    rd_word    = mem_q[ptr_q];
    stat_word  = '0;
    stat_word[WORD_BITS-1 -: 8] = {6'b0, last_err_q, wrapped_q};
    if (csb_rise) begin
      state_d = S_IDLE;
      cnt_d   = '0;
      done_d  = 1'b1;
    end else if (csb_fall) begin
      state_d = S_CMD;
      cnt_d   = '0;
    end else begin
      case (state_q)
        S_CMD: if (smp_edge) begin
          rx_d  = rx_next[RX_W-2:0];
          cnt_d = cnt_q + 6'd1;
          if (cnt_q == BYTE_LAST) begin
            cnt_d = '0;
            case (rx_next[7:0])
              8'h02, 8'h03: begin
                state_d    = S_ADDR;
                is_rd_d    = rx_next[0];
                last_err_d = 1'b0;
                wrapped_d  = 1'b0;
              end
              8'h05:   state_d = S_STATUS;
              default: begin
                state_d    = S_IGNORE;
                cmd_err_d  = 1'b1;
                last_err_d = 1'b1;
              end
            endcase
          end
        end
        S_ADDR: if (smp_edge) begin
          rx_d  = rx_next[RX_W-2:0];
          cnt_d = cnt_q + 6'd1;
          if (cnt_q == ADDR_LAST) begin
            cnt_d   = '0;
            ptr_d   = rx_next[ADDR_W-1:0];
            state_d = is_rd_q ? S_RDATA : S_WDATA;
          end
        end
        S_RDATA: begin
          // Count 0 at a shift edge means a fresh word: fetch it and present its MSB.
          if (shf_edge) begin
            if (cnt_q == '0) begin
              miso_d = rd_word[WORD_BITS-1];
              tx_d   = rd_word << 1;
            end else begin
              miso_d = tx_q[WORD_BITS-1];
              tx_d   = tx_q << 1;
            end
          end
          if (smp_edge) begin
            cnt_d = cnt_q + 6'd1;
            if (cnt_q == WORD_LAST) begin
              cnt_d = '0;
              ptr_d = ptr_q + 1'b1;
              if (&ptr_q) wrapped_d = 1'b1;
            end
          end
        end
        S_STATUS: begin
          if (shf_edge) begin
            if (cnt_q == '0) begin
              miso_d = stat_word[WORD_BITS-1];
              tx_d   = stat_word << 1;
            end else begin
              miso_d = tx_q[WORD_BITS-1];
              tx_d   = tx_q << 1;
            end
          end
          if (smp_edge) cnt_d = (cnt_q == BYTE_LAST) ? 6'd0 : cnt_q + 6'd1;
        end
        S_WDATA: if (smp_edge) begin
          rx_d  = rx_next[RX_W-2:0];
          cnt_d = cnt_q + 6'd1;
          if (cnt_q == WORD_LAST) begin
            cnt_d  = '0;
            mem_we = 1'b1;
            ptr_d  = ptr_q + 1'b1;
            if (&ptr_q) wrapped_d = 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign busy        = ~csb_s_q;
  assign spi_miso_oe = ((state_q == S_RDATA) || (state_q == S_STATUS)) & ~csb_s_q;
  assign spi_miso    = spi_miso_oe & miso_q;
  assign xfer_done   = done_q;
  assign cmd_err     = cmd_err_q;
  assign bd_rdata    = bd_rdata_q;

endmodule
`default_nettype wire

// File: tb/tb_spi_slave_mem.sv
`timescale 1ns/1ps
`default_nettype none
// tb_spi_slave_mem -- directed bench: mode-0 byte instance and mode-3 32-bit instance.
// Revision 1.0
module tb_spi_slave_mem;
  localparam int HALF = 80;

  logic clk = 1'b0;
  logic resetn = 1'b0;
  always #5 clk = ~clk;

  logic csb0 = 1'b1, sck0 = 1'b0, mosi0 = 1'b0;
  logic miso0, oe0, busy0, done0, err0;
  logic bd_we0 = 1'b0;
  logic [7:0] bd_addr0 = 8'h00, bd_wdata0 = 8'h00;
  logic [7:0] bd_rdata0;

  logic csb1 = 1'b1, sck1 = 1'b1, mosi1 = 1'b0;
  logic miso1, oe1, busy1, done1, err1;
  logic bd_we1 = 1'b0;
  logic [7:0] bd_addr1 = 8'h00;
  logic [31:0] bd_wdata1 = 32'h0;
  logic [31:0] bd_rdata1;

  int checks = 0;
  int errors = 0;
  int done0_cnt = 0, err0_cnt = 0, oe0_cnt = 0;

  spi_slave_mem dut0 (
    .clk(clk), .resetn(resetn), .spi_csb(csb0), .spi_sck(sck0), .spi_mosi(mosi0),
    .spi_miso(miso0), .spi_miso_oe(oe0), .bd_we(bd_we0), .bd_addr(bd_addr0),
    .bd_wdata(bd_wdata0), .bd_rdata(bd_rdata0), .busy(busy0), .xfer_done(done0), .cmd_err(err0)
  );

  spi_slave_mem #(.WORD_BITS(32), .ADDR_BYTES(2), .DEPTH(256), .CPOL(1'b1), .CPHA(1'b1)) dut1 (
    .clk(clk), .resetn(resetn), .spi_csb(csb1), .spi_sck(sck1), .spi_mosi(mosi1),
    .spi_miso(miso1), .spi_miso_oe(oe1), .bd_we(bd_we1), .bd_addr(bd_addr1),
    .bd_wdata(bd_wdata1), .bd_rdata(bd_rdata1), .busy(busy1), .xfer_done(done1), .cmd_err(err1)
  );

  always @(posedge clk) begin
    if (done0) done0_cnt <= done0_cnt + 1;
    if (err0)  err0_cnt  <= err0_cnt + 1;
    if (oe0)   oe0_cnt   <= oe0_cnt + 1;
  end

  task automatic spi_start(input int sel);
    @(negedge clk);
    if (sel == 0) csb0 = 1'b0; else csb1 = 1'b0;
    #50;
  endtask

  task automatic spi_stop(input int sel);
    #HALF;
    if (sel == 0) csb0 = 1'b1; else csb1 = 1'b1;
    #100;
  endtask

  // Mode 0 for instance 0, mode 3 for instance 1; tx bits taken MSB first.
  task automatic spi_bits(input int sel, input int n, input logic [7:0] tx, output logic [7:0] rx);
    rx = 8'h00;
    for (int i = 0; i < n; i++) begin
      if (sel == 0) begin
        mosi0 = tx[7-i];
        #HALF;
        rx = {rx[6:0], miso0};
        sck0 = 1'b1;
        #HALF;
        sck0 = 1'b0;
      end else begin
        sck1 = 1'b0;
        mosi1 = tx[7-i];
        #HALF;
        rx = {rx[6:0], miso1};
        sck1 = 1'b1;
        #HALF;
      end
    end
  endtask

  task automatic spi_byte(input int sel, input logic [7:0] tx, output logic [7:0] rx);
    spi_bits(sel, 8, tx, rx);
  endtask

  task automatic poke0(input logic [7:0] a, input logic [7:0] d);
    @(negedge clk);
    bd_addr0 = a; bd_wdata0 = d; bd_we0 = 1'b1;
    @(negedge clk);
    bd_we0 = 1'b0;
  endtask

  task automatic peek0(input logic [7:0] a, output logic [7:0] d);
    @(negedge clk);
    bd_addr0 = a;
    @(negedge clk);
    d = bd_rdata0;
  endtask

  task automatic test_reset;
    resetn = 1'b0;
    repeat (4) @(negedge clk);
    checks++; if (miso0 !== 1'b0) begin errors++; $display("FAIL reset_miso: got %b want 0", miso0); end
    checks++; if (oe0 !== 1'b0) begin errors++; $display("FAIL reset_oe: got %b want 0", oe0); end
    checks++; if (busy0 !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", busy0); end
    checks++; if (done0 !== 1'b0) begin errors++; $display("FAIL reset_done: got %b want 0", done0); end
    checks++; if (err0 !== 1'b0) begin errors++; $display("FAIL reset_cmd_err: got %b want 0", err0); end
    checks++; if (bd_rdata1 !== 32'h0) begin errors++; $display("FAIL reset_bd_rdata: got %h want 0", bd_rdata1); end
    resetn = 1'b1;
    repeat (5) @(negedge clk);
  endtask

  task automatic test_read_stream;
    logic [7:0] r, r1, r2;
    int d0;
    poke0(8'h10, 8'hA5);
    poke0(8'h11, 8'h3C);
    peek0(8'h10, r);
    checks++; if (r !== 8'hA5) begin errors++; $display("FAIL bd_readback: got %h want a5", r); end
    d0 = done0_cnt;
    spi_start(0);
    spi_byte(0, 8'h03, r);
    checks++; if (busy0 !== 1'b1) begin errors++; $display("FAIL busy_in_xfer: got %b want 1", busy0); end
    spi_byte(0, 8'h10, r);
    spi_byte(0, 8'h00, r1);
    spi_byte(0, 8'h00, r2);
    spi_stop(0);
    checks++; if (r1 !== 8'hA5) begin errors++; $display("FAIL read_word0: got %h want a5", r1); end
    checks++; if (r2 !== 8'h3C) begin errors++; $display("FAIL read_word1: got %h want 3c", r2); end
    checks++; if (done0_cnt - d0 !== 1) begin errors++; $display("FAIL read_xfer_done: got %0d pulses want 1", done0_cnt - d0); end
    checks++; if (busy0 !== 1'b0) begin errors++; $display("FAIL busy_after_xfer: got %b want 0", busy0); end
  endtask

  task automatic test_write_wrap;
    logic [7:0] r, r1, r2;
    spi_start(0);
    spi_byte(0, 8'h02, r);
    spi_byte(0, 8'hFE, r);
    spi_byte(0, 8'h11, r);
    spi_byte(0, 8'h22, r);
    spi_byte(0, 8'h33, r);
    spi_stop(0);
    peek0(8'hFE, r);
    checks++; if (r !== 8'h11) begin errors++; $display("FAIL wr_fe: got %h want 11", r); end
    peek0(8'hFF, r);
    checks++; if (r !== 8'h22) begin errors++; $display("FAIL wr_ff: got %h want 22", r); end
    peek0(8'h00, r);
    checks++; if (r !== 8'h33) begin errors++; $display("FAIL wr_wrap_00: got %h want 33", r); end
    spi_start(0);
    spi_byte(0, 8'h05, r);
    spi_byte(0, 8'h00, r1);
    spi_byte(0, 8'h00, r2);
    spi_stop(0);
    checks++; if (r1 !== 8'h01) begin errors++; $display("FAIL status_wrapped: got %h want 01", r1); end
    checks++; if (r2 !== 8'h01) begin errors++; $display("FAIL status_repeat: got %h want 01", r2); end
  endtask

  task automatic test_bad_cmd;
    logic [7:0] r;
    int e0, o0, d0;
    e0 = err0_cnt; o0 = oe0_cnt; d0 = done0_cnt;
    spi_start(0);
    spi_byte(0, 8'h7E, r);
    spi_byte(0, 8'hFF, r);
    spi_stop(0);
    checks++; if (err0_cnt - e0 !== 1) begin errors++; $display("FAIL bad_cmd_err: got %0d pulses want 1", err0_cnt - e0); end
    checks++; if (oe0_cnt - o0 !== 0) begin errors++; $display("FAIL bad_cmd_oe: got %0d cycles want 0", oe0_cnt - o0); end
    checks++; if (done0_cnt - d0 !== 1) begin errors++; $display("FAIL bad_cmd_done: got %0d pulses want 1", done0_cnt - d0); end
    spi_start(0);
    spi_byte(0, 8'h05, r);
    spi_byte(0, 8'h00, r);
    spi_stop(0);
    checks++; if ((r & 8'h02) !== 8'h02) begin errors++; $display("FAIL status_last_err: got %h want bit1 set", r); end
  endtask

  task automatic test_partial_write;
    logic [7:0] r;
    poke0(8'h20, 8'h5A);
    spi_start(0);
    spi_byte(0, 8'h02, r);
    spi_byte(0, 8'h20, r);
    spi_bits(0, 5, 8'hF8, r);
    spi_stop(0);
    peek0(8'h20, r);
    checks++; if (r !== 8'h5A) begin errors++; $display("FAIL partial_discard: got %h want 5a", r); end
    spi_start(0);
    spi_byte(0, 8'h03, r);
    spi_byte(0, 8'h20, r);
    spi_byte(0, 8'h00, r);
    spi_stop(0);
    checks++; if (r !== 8'h5A) begin errors++; $display("FAIL after_partial_read: got %h want 5a", r); end
  endtask

  task automatic test_mode3_32;
    logic [7:0] r, b0, b1, b2, b3;
    logic [31:0] bd;
    spi_start(1);
    spi_byte(1, 8'h02, r);
    spi_byte(1, 8'h00, r);
    spi_byte(1, 8'h04, r);
    spi_byte(1, 8'hDE, r);
    spi_byte(1, 8'hAD, r);
    spi_byte(1, 8'hBE, r);
    spi_byte(1, 8'hEF, r);
    spi_stop(1);
    @(negedge clk);
    bd_addr1 = 8'h04;
    @(negedge clk);
    bd = bd_rdata1;
    checks++; if (bd !== 32'hDEADBEEF) begin errors++; $display("FAIL m3_bd_word: got %h want deadbeef", bd); end
    spi_start(1);
    spi_byte(1, 8'h03, r);
    spi_byte(1, 8'h00, r);
    spi_byte(1, 8'h04, r);
    spi_byte(1, 8'h00, b0);
    spi_byte(1, 8'h00, b1);
    spi_byte(1, 8'h00, b2);
    spi_byte(1, 8'h00, b3);
    spi_stop(1);
    checks++; if ({b0, b1, b2, b3} !== 32'hDEADBEEF) begin errors++; $display("FAIL m3_spi_read: got %h want deadbeef", {b0, b1, b2, b3}); end
  endtask

  task automatic test_reset_mid_read;
    logic [7:0] r, r1, r2;
    int o0;
    spi_start(0);
    spi_byte(0, 8'h03, r);
    spi_byte(0, 8'h10, r);
    spi_bits(0, 4, 8'h00, r);
    checks++; if (oe0 !== 1'b1) begin errors++; $display("FAIL mid_read_oe: got %b want 1", oe0); end
    @(negedge clk);
    resetn = 1'b0;
    @(negedge clk);
    checks++; if (oe0 !== 1'b0) begin errors++; $display("FAIL rst_mid_oe: got %b want 0", oe0); end
    checks++; if (miso0 !== 1'b0) begin errors++; $display("FAIL rst_mid_miso: got %b want 0", miso0); end
    checks++; if (busy0 !== 1'b0) begin errors++; $display("FAIL rst_mid_busy: got %b want 0", busy0); end
    checks++; if (bd_rdata0 !== 8'h00) begin errors++; $display("FAIL rst_mid_bd_rdata: got %h want 00", bd_rdata0); end
    repeat (2) @(negedge clk);
    resetn = 1'b1;
    o0 = oe0_cnt;
    spi_bits(0, 8, 8'h00, r);
    checks++; if (busy0 !== 1'b1) begin errors++; $display("FAIL rst_held_busy: got %b want 1", busy0); end
    checks++; if (oe0_cnt - o0 !== 0) begin errors++; $display("FAIL rst_wait_idle: got %0d oe cycles want 0", oe0_cnt - o0); end
    spi_stop(0);
    spi_start(0);
    spi_byte(0, 8'h03, r);
    spi_byte(0, 8'h10, r);
    spi_byte(0, 8'h00, r1);
    spi_byte(0, 8'h00, r2);
    spi_stop(0);
    checks++; if (r1 !== 8'hA5) begin errors++; $display("FAIL mem_kept0: got %h want a5", r1); end
    checks++; if (r2 !== 8'h3C) begin errors++; $display("FAIL mem_kept1: got %h want 3c", r2); end
  endtask

  initial begin
    test_reset();
    test_read_stream();
    test_write_wrap();
    test_bad_cmd();
    test_partial_write();
    test_mode3_32();
    test_reset_mid_read();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
